// File: rtl/tx_pulser.sv
// rtl/tx_pulser.sv - per-element bipolar burst pulser triggered by rising edges of the fire vector
// Optional one-cycle dead time around every phase switch: define TX_PULSER_DEADTIME_EN.
module tx_pulser #(
   parameter int NUM_CH = 64,
   parameter int HP_W   = 4,
   parameter int NC_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [NUM_CH-1:0] tx_in,
   input  logic [HP_W-1:0]   half_period,
   input  logic [NC_W-1:0]   num_cycles,
   output logic [NUM_CH-1:0] pulse_p,
   output logic [NUM_CH-1:0] pulse_n,
   output logic [NUM_CH-1:0] busy,
   output logic              all_idle
);

`ifdef TX_PULSER_DEADTIME_EN
   typedef enum logic [2:0] {IDLE, POS, NEG, DEAD_PN, DEAD_NP} state_t;
`else
   typedef enum logic [1:0] {IDLE, POS, NEG} state_t;
`endif

   // tx_in is captured once before edge detection, so an edge sampled at
   // edge t shows up at the drive outputs from edge t+1.
   logic [NUM_CH-1:0] tx_q, tx_d;
   logic [NUM_CH-1:0] prev_q, prev_d;
   logic [NUM_CH-1:0] pulse_p_q, pulse_p_d;
   logic [NUM_CH-1:0] pulse_n_q, pulse_n_d;
   logic [NUM_CH-1:0] busy_q, busy_d;
   logic              all_idle_q, all_idle_d;

   state_t            state_q [NUM_CH];
   state_t            state_d [NUM_CH];
   logic [HP_W-1:0]   h_q     [NUM_CH];
   logic [HP_W-1:0]   h_d     [NUM_CH];
   logic [HP_W-1:0]   hcnt_q  [NUM_CH];
   logic [HP_W-1:0]   hcnt_d  [NUM_CH];
   logic [NC_W-1:0]   ncnt_q  [NUM_CH];
   logic [NC_W-1:0]   ncnt_d  [NUM_CH];

   logic [HP_W-1:0]   h_eff;
   logic              arm_ok;

   always_comb begin
      tx_d       = tx_in;
      prev_d     = tx_q;
      pulse_p_d  = '0;
      pulse_n_d  = '0;
      busy_d     = '0;
      all_idle_d = ~|busy_q;
      h_eff      = (half_period == '0) ? HP_W'(1) : half_period;
      arm_ok     = enable && (num_cycles != '0);

      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         h_d[i]     = h_q[i];
         hcnt_d[i]  = hcnt_q[i];
         ncnt_d[i]  = ncnt_q[i];

         if (!enable) begin
            state_d[i] = IDLE;
            hcnt_d[i]  = '0;
            ncnt_d[i]  = '0;
         end else begin
            case (state_q[i])
               IDLE: begin
                  if (arm_ok && tx_q[i] && !prev_q[i]) begin
                     state_d[i] = POS;
                     h_d[i]     = h_eff;
                     hcnt_d[i]  = h_eff - HP_W'(1);
                     ncnt_d[i]  = num_cycles;
                  end
               end
               POS: begin
                  if (hcnt_q[i] == '0) begin
`ifdef TX_PULSER_DEADTIME_EN
                     state_d[i] = DEAD_PN;
`else
                     state_d[i] = NEG;
                     hcnt_d[i]  = h_q[i] - HP_W'(1);
`endif
                  end else begin
                     hcnt_d[i] = hcnt_q[i] - HP_W'(1);
                  end
               end
               NEG: begin
                  if (hcnt_q[i] == '0) begin
                     ncnt_d[i] = ncnt_q[i] - NC_W'(1);
                     if (ncnt_q[i] == NC_W'(1)) begin
                        state_d[i] = IDLE;
                     end else begin
`ifdef TX_PULSER_DEADTIME_EN
                        state_d[i] = DEAD_NP;
`else
                        state_d[i] = POS;
                        hcnt_d[i]  = h_q[i] - HP_W'(1);
`endif
                     end
                  end else begin
                     hcnt_d[i] = hcnt_q[i] - HP_W'(1);
                  end
               end
`ifdef TX_PULSER_DEADTIME_EN
               DEAD_PN: begin
                  state_d[i] = NEG;
                  hcnt_d[i]  = h_q[i] - HP_W'(1);
               end
               DEAD_NP: begin
                  state_d[i] = POS;
                  hcnt_d[i]  = h_q[i] - HP_W'(1);
               end
`endif
               default: begin
                  state_d[i] = IDLE;
               end
            endcase
         end

         // Outputs decode the next state so they are flops aligned with it.
         pulse_p_d[i] = (state_d[i] == POS);
         pulse_n_d[i] = (state_d[i] == NEG);
         busy_d[i]    = (state_d[i] != IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q       <= '1;
         prev_q     <= '1;
         pulse_p_q  <= '0;
         pulse_n_q  <= '0;
         busy_q     <= '0;
         all_idle_q <= 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= IDLE;
            h_q[i]     <= '0;
            hcnt_q[i]  <= '0;
            ncnt_q[i]  <= '0;
         end
      end else begin
         tx_q       <= tx_d;
         prev_q     <= prev_d;
         pulse_p_q  <= pulse_p_d;
         pulse_n_q  <= pulse_n_d;
         busy_q     <= busy_d;
         all_idle_q <= all_idle_d;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            h_q[i]     <= h_d[i];
            hcnt_q[i]  <= hcnt_d[i];
            ncnt_q[i]  <= ncnt_d[i];
         end
      end
   end

   assign pulse_p  = pulse_p_q;
   assign pulse_n  = pulse_n_q;
   assign busy     = busy_q;
   assign all_idle = all_idle_q;

endmodule
